// File: rtl/fetch_ctrl_if.sv
// Fetch/decode/code-memory bundle for fetch_ctrl.
//   pc_o            fetch address to code memory (word-aligned)
//   inst_i          code memory read data for last cycle's pc_o
//   inst_o          instruction at buffer head
//   inst_pc_o       byte address of inst_o
//   inst_valid_o    head holds a live instruction
//   inst_ready_i    decode accepts head
//   branch_i        single-cycle redirect request
//   branch_target_i redirect address (low two bits ignored)
//   halt_i          suppress new fetch issue
//   fault_o         sticky out-of-range fetch fault
// master: fetch_ctrl side; slave: memory/decode/environment side.
interface fetch_ctrl_if;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        halt_i;
  logic        fault_o;

  modport master (
    output pc_o, inst_o, inst_pc_o, inst_valid_o, fault_o,
    input  inst_i, inst_ready_i, branch_i, branch_target_i, halt_i
  );

  modport slave (
    input  pc_o, inst_o, inst_pc_o, inst_valid_o, fault_o,
    output inst_i, inst_ready_i, branch_i, branch_target_i, halt_i
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer for a registered-read code memory.
// Owns the PC, issues one word-aligned read per cycle, tracks the single
// read in flight and captures returned words into a 2-entry buffer that
// feeds decode under valid/ready. Handles branch redirects, halt and
// out-of-range fetch faults.
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    fetch_ctrl_if.master (see interface header for signals)
module fetch_ctrl #(
  parameter int unsigned MEM_BYTES = 68,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_ctrl_if.master  bus
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 2;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       req_pc_q;
  logic              inflight_q;
  logic              fault_q, fault_d;
  logic [CW-1:0]     count_q, count_d;
  logic              head_q;
  logic              tail;
  logic [31:0]       buf_inst_q [DEPTH];
  logic [31:0]       buf_pc_q   [DEPTH];

  logic              pop;
  logic              capture;
  logic              issue;
  logic              in_range;
  logic              has_room;
  logic [2:0]        occupancy;

  // Handshake and buffer bookkeeping; a branch squashes both pop and capture.
  always_comb begin
    pop       = (count_q != '0) & bus.inst_ready_i & ~bus.branch_i;
    capture   = inflight_q & ~bus.branch_i;
    in_range  = pc_q < 32'(MEM_BYTES);
    // Occupancy after this cycle's pop, counting the read in flight.
    occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    has_room  = occupancy < 3'd2;
    // Tail slot; with a full buffer it aliases the head, which pop frees.
    tail      = head_q ^ count_q[0];
    if (bus.branch_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(capture) - CW'(pop);
    end
  end

  // Next-state and issue decision.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    issue   = 1'b0;
    if (bus.branch_i) begin
      state_d = RUN;
      pc_d    = bus.branch_target_i & ~32'h3;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (!bus.halt_i) begin
            if (!in_range) begin
              state_d = FAULT;
              fault_d = 1'b1;
            end else if (has_room) begin
              issue = 1'b1;
              pc_d  = pc_q + 32'd4;
            end
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // FSM and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // In-flight read tracking; reset drops any read that is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        req_pc_q <= pc_q;
      end
    end
  end

  // Two-entry instruction buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      head_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_inst_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      if (!bus.branch_i) begin
        head_q <= head_q ^ pop;
      end
      if (capture) begin
        buf_inst_q[tail] <= bus.inst_i;
        buf_pc_q[tail]   <= req_pc_q;
      end
    end
  end

  // The issue rule must keep a capture from landing on a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(capture && !pop && count_q == CW'(DEPTH)));

  assign bus.pc_o         = pc_q;
  assign bus.inst_valid_o = (count_q != '0);
  assign bus.inst_o       = buf_inst_q[head_q];
  assign bus.inst_pc_o    = buf_pc_q[head_q];
  assign bus.fault_o      = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  localparam int unsigned MEMB = 68;

  logic clk;
  logic reset;
  fetch_ctrl_if bus();

  fetch_ctrl #(.MEM_BYTES(MEMB), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr >= 32'(MEMB)) return 32'hDEAD_BEEF;
    case (addr[31:2])
      30'd0:   return 32'hE093_4081;
      30'd1:   return 32'hE012_4001;
      default: return {16'hC0DE, addr[15:0]};
    endcase
  endfunction

  // Registered-read code memory.
  always @(posedge clk) bus.inst_i <= mem_word(bus.pc_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic h, input logic r, input logic b, input logic [31:0] t);
    bus.halt_i          = h;
    bus.inst_ready_i    = r;
    bus.branch_i        = b;
    bus.branch_target_i = t;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc_o"},    bus.pc_o, 32'h0);
    chk({tag, "_valid"},   32'(bus.inst_valid_o), 32'h0);
    chk({tag, "_inst"},    bus.inst_o, 32'h0);
    chk({tag, "_inst_pc"}, bus.inst_pc_o, 32'h0);
    chk({tag, "_fault"},   32'(bus.fault_o), 32'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        halt;
    logic        ready;
    logic        branch;
    logic [31:0] tgt;
    logic        exp_valid;
    logic [31:0] exp_pc_o;
    logic [31:0] exp_ipc;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [27];

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpend[$];
  logic [31:0] mpc;
  bit          mfault;

  task automatic model_reset();
    mq.delete();
    mpend.delete();
    mpc    = 32'h0;
    mfault = 1'b0;
  endtask

  task automatic model_step(input logic h, input logic r, input logic b, input logic [31:0] t);
    bit pop;
    int occ;
    pop = (mq.size() != 0) && r && !b;
    if (b) begin
      mq.delete();
      mpend.delete();
      mpc    = {t[31:2], 2'b00};
      mfault = 1'b0;
    end else begin
      occ = mq.size() + mpend.size() - (pop ? 1 : 0);
      if (pop) void'(mq.pop_front());
      if (mpend.size() != 0) mq.push_back('{mem_word(mpend[0]), mpend[0]});
      mpend.delete();
      if (!mfault && !h) begin
        if (mpc >= 32'(MEMB)) mfault = 1'b1;
        else if (occ < 2) begin
          mpend.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
    end
  endtask

  task automatic model_check(input string tag);
    bit v;
    v = (mq.size() != 0);
    chk({tag, "_pc_o"},  bus.pc_o, mpc);
    chk({tag, "_valid"}, 32'(bus.inst_valid_o), 32'(v));
    chk({tag, "_fault"}, 32'(bus.fault_o), 32'(mfault));
    if (v && bus.inst_valid_o) begin
      chk({tag, "_inst"},    bus.inst_o, mq[0].inst);
      chk({tag, "_inst_pc"}, bus.inst_pc_o, mq[0].pc);
    end
  endtask

  task automatic run_random(input int n, input string tag);
    logic h, r, b;
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      h = ($urandom % 8) == 0;
      r = ($urandom % 4) != 0;
      b = ($urandom % 16) == 0;
      t = 32'($urandom_range(0, 84));
      drive(h, r, b, t);
      @(negedge clk);
      model_check(tag);
      model_step(h, r, b, t);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Rows: halt, ready, branch, target | valid, pc_o, inst_pc, fault
    vecs[0]  = '{0, 1, 0, 32'h00, 0, 32'h00, 32'h00, 0};
    vecs[1]  = '{0, 1, 0, 32'h00, 0, 32'h04, 32'h00, 0};
    vecs[2]  = '{0, 0, 0, 32'h00, 1, 32'h08, 32'h00, 0};
    vecs[3]  = '{0, 0, 0, 32'h00, 1, 32'h08, 32'h00, 0};
    vecs[4]  = '{0, 0, 0, 32'h00, 1, 32'h08, 32'h00, 0};
    vecs[5]  = '{0, 0, 0, 32'h00, 1, 32'h08, 32'h00, 0};
    vecs[6]  = '{0, 0, 0, 32'h00, 1, 32'h08, 32'h00, 0};
    vecs[7]  = '{0, 1, 0, 32'h00, 1, 32'h08, 32'h00, 0};
    vecs[8]  = '{0, 1, 0, 32'h00, 1, 32'h0C, 32'h04, 0};
    vecs[9]  = '{0, 1, 0, 32'h00, 1, 32'h10, 32'h08, 0};
    vecs[10] = '{0, 1, 1, 32'h3A, 1, 32'h14, 32'h0C, 0};
    vecs[11] = '{0, 1, 0, 32'h00, 0, 32'h38, 32'h00, 0};
    vecs[12] = '{0, 1, 0, 32'h00, 0, 32'h3C, 32'h00, 0};
    vecs[13] = '{0, 1, 0, 32'h00, 1, 32'h40, 32'h38, 0};
    vecs[14] = '{0, 1, 0, 32'h00, 1, 32'h44, 32'h3C, 0};
    vecs[15] = '{0, 1, 0, 32'h00, 1, 32'h44, 32'h40, 1};
    vecs[16] = '{0, 1, 1, 32'h00, 0, 32'h44, 32'h00, 1};
    vecs[17] = '{0, 1, 0, 32'h00, 0, 32'h00, 32'h00, 0};
    vecs[18] = '{1, 1, 0, 32'h00, 0, 32'h04, 32'h00, 0};
    vecs[19] = '{1, 1, 0, 32'h00, 1, 32'h04, 32'h00, 0};
    vecs[20] = '{1, 1, 0, 32'h00, 0, 32'h04, 32'h00, 0};
    vecs[21] = '{0, 0, 0, 32'h00, 0, 32'h04, 32'h00, 0};
    vecs[22] = '{0, 0, 0, 32'h00, 0, 32'h08, 32'h00, 0};
    vecs[23] = '{0, 1, 1, 32'h10, 1, 32'h0C, 32'h04, 0};
    vecs[24] = '{0, 1, 0, 32'h00, 0, 32'h10, 32'h00, 0};
    vecs[25] = '{0, 1, 0, 32'h00, 0, 32'h14, 32'h00, 0};
    vecs[26] = '{0, 1, 0, 32'h00, 1, 32'h18, 32'h10, 0};

    reset = 1'b1;
    drive(0, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Directed table from reset release.
    foreach (vecs[i]) begin
      drive(vecs[i].halt, vecs[i].ready, vecs[i].branch, vecs[i].tgt);
      @(negedge clk);
      chk($sformatf("vec%0d_pc_o", i),  bus.pc_o, vecs[i].exp_pc_o);
      chk($sformatf("vec%0d_valid", i), 32'(bus.inst_valid_o), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_fault", i), 32'(bus.fault_o), 32'(vecs[i].exp_fault));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_inst_pc", i), bus.inst_pc_o, vecs[i].exp_ipc);
        chk($sformatf("vec%0d_inst", i),    bus.inst_o, mem_word(vecs[i].exp_ipc));
      end
      @(posedge clk);
      #1;
    end

    // Async reset mid-stream, asserted and released between edges.
    drive(0, 1, 0, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();

    // Restart with ready high: first instruction two cycles after release.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 32'h0);
      @(negedge clk);
      model_check("restart");
      model_step(0, 1, 0, 32'h0);
      @(posedge clk);
      #1;
    end

    run_random(2500, "rand");

    // Second mid-stream reset after random traffic, then more random traffic.
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset2");
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    model_step(bus.halt_i, bus.inst_ready_i, bus.branch_i, bus.branch_target_i);
    run_random(1500, "rand2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction fetch sequencer for the byte-addressed, registered-read code memory: one read per cycle, data on the cycle after the address is driven.
- Owns the program counter and issues word-aligned fetch addresses.
- Tracks the one-cycle-latency read in flight and captures returned words into a 2-entry buffer.
- Presents instructions with their PC to decode under a valid/ready handshake; handles branch redirects, external halt and out-of-range fetch faults.

Parameters:
MEM_BYTES, 68, size of code memory in bytes; a fetch address >= MEM_BYTES faults.
RESET_PC, 0, PC loaded on reset; must be word-aligned.

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
pc_o  output  32  fetch address to code memory pc_i; always word-aligned
inst_i  input  32  code memory read data; holds mem[pc_o of previous cycle]
inst_o  output  32  buffered instruction at buffer head
inst_pc_o  output  32  byte address of inst_o
inst_valid_o  output  1  buffer head holds a live instruction
inst_ready_i  input  1  decode accepts head this cycle
branch_i  input  1  redirect request, single-cycle pulse
branch_target_i  input  32  redirect address; bits [1:0] forced to 0
halt_i  input  1  suppress new fetch issue while high
fault_o  output  1  fetch address out of range; sticky until redirect

Behaviour:
- Reset (async) values:
  - pc_q = RESET_PC; pc_o = RESET_PC.
  - Buffer count = 0; inflight_q = 0; state = RUN.
  - inst_valid_o = 0; inst_o = 0; inst_pc_o = 0; fault_o = 0.
- Reset asserted mid-operation: in-flight read discarded; the inst_i returned next cycle is ignored.
- pop = inst_valid_o & inst_ready_i & ~branch_i.
- Issue, in state RUN only: issue = ~halt_i & ~branch_i & (pc_q < MEM_BYTES) & (count + inflight_q - pop < 2).
  - pc_o = pc_q at all times.
  - On issue: inflight_q <= 1, req_pc_q <= pc_q, pc_q <= pc_q + 4. Otherwise inflight_q <= 0.
- Capture: when inflight_q = 1 and not squashed, {inst_i, req_pc_q} is written to the buffer tail at the clock edge.
  - Buffer never overflows; the issue rule guarantees this. Overflow is an assertion failure.
- Output: inst_valid_o = (count != 0); inst_o / inst_pc_o are driven from the head entry. Pop advances the head.
- Simultaneous capture and pop: count is unchanged, FIFO order is preserved.
- Latency:
  - Address issued in cycle N is captured at the end of N+1 and is visible on inst_valid_o in N+2.
  - With inst_ready_i held high, steady-state throughput is 1 instruction/cycle.
- Branch (branch_i = 1 in cycle N):
  - Buffer is flushed (count <= 0); inflight_q <= 0, so the read returning in N+1 is squashed.
  - pc_q <= {branch_target_i[31:2], 2'b00}; fault_o <= 0; state <= RUN.
  - A head presented in cycle N is not consumed (pop forced 0).
  - Target is issued in N+1 and becomes valid in N+3.
  - Branch has priority over halt, pop and fault.
- FSM states:
  - RUN: normal issue. pc_q >= MEM_BYTES with ~halt_i & ~branch_i -> FAULT, fault_o <= 1, no issue.
    - Entries already buffered or in flight still drain normally.
  - FAULT: no issue; buffer drains via pop. Only branch_i leaves FAULT, going to RUN.
    - A branch to an out-of-range target re-enters FAULT on the next cycle.
- Halt: halt_i blocks issue only. In-flight capture and pop continue; no state change.
- Wrap: pc_q + 4 is 32-bit modulo. The range check catches overrun before any wrap reaches memory.

Test Plan:
- Reset, ready=1, no branch → pc_o 0,4,8,… one per cycle. inst_valid_o first high 2 cycles after reset release, with inst_o=0xE0934081, inst_pc_o=0. Next cycle inst_o=0xE0124001, inst_pc_o=4.
- Backpressure → hold ready=0 for 5 cycles after first valid. Buffer fills to 2 and pc_o stalls at 8. inst_o stays 0xE0934081. On ready=1, PCs 0,4,8 are delivered in order, none lost or duplicated.
- Branch → branch_i in cycle N, target 0x3A. Buffer and in-flight flushed; pc_o=0x38 in N+1; inst_valid_o low in N+1..N+2. In N+3: inst_pc_o=0x38, inst_o=mem[0x38..0x3B].
- Fault → run to PC 0x44 with MEM_BYTES=68. fault_o rises, pc_o holds 0x44, word 0x40 still delivered. Branch to 0 clears fault_o and restarts fetch at 0.
- Halt and collision → halt_i high for 3 cycles: no new pc_o advance, in-flight word still delivered. Branch in the same cycle as a pop: the head is not counted as consumed.
- Async reset → assert reset mid-stream, between clock edges. Outputs clear immediately; after release fetch restarts at RESET_PC, with no stale instruction from before reset.
